// File: rtl/tx_rs_pkg.sv
// ---------------------------------------------------------------------------
// tx_rs_pkg
// Shared definitions for the RS-block TX framer: FSM state encoding, counter
// widths and the small elaboration-time helpers used to size ports and derive
// the check-slot count of each RS block.
// ---------------------------------------------------------------------------
package tx_rs_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOF,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_DUMMY,
        ST_CHECK
    } tx_state_t;

    localparam int BLK_W = 10;
    localparam int LEN_W = 15;

    // Ceiling log2, usable in parameter and port-width expressions.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // Byte-enable / lane-select width; a single-lane word still needs one bit.
    function automatic int be_width(input int in_bytes);
        return (clog2(in_bytes) < 1) ? 1 : clog2(in_bytes);
    endfunction

    // Check-slot cycles per block: parity symbols plus encoder latency slack.
    function automatic int rs_r(input int rs_n, input int rs_k, input int chk_pad);
        return rs_n - rs_k + chk_pad;
    endfunction

endpackage

// File: rtl/tx_byte_unpacker.sv
// ---------------------------------------------------------------------------
// tx_byte_unpacker
// Word-to-byte lane selection for the TX framer. Picks byte i_bsel of the
// current input word, decides whether that byte is the last one of the word
// (the EOF word may be short, as given by i_be) and produces the word ack
// together with the next lane index.
//
// Ports:
//   i_data      input word, byte 0 in bits [7:0]
//   i_be        index of last valid byte, only meaningful with i_eof
//   i_eof       current word is the last of the frame
//   i_val       current word is valid
//   i_active    framer is in its payload state
//   i_bsel      lane currently being emitted
//   o_byte      selected lane
//   o_ack       word fully consumed this cycle
//   o_eof_sent  final byte of the frame consumed this cycle
//   o_bsel_nxt  lane index for the following cycle
// ---------------------------------------------------------------------------
module tx_byte_unpacker
    import tx_rs_pkg::*;
#(
    parameter int IN_BYTES = 4,
    parameter int BE_W     = be_width(IN_BYTES)
) (
    input  logic [8*IN_BYTES-1:0] i_data,
    input  logic [BE_W-1:0]       i_be,
    input  logic                  i_eof,
    input  logic                  i_val,
    input  logic                  i_active,
    input  logic [BE_W-1:0]       i_bsel,
    output logic [7:0]            o_byte,
    output logic                  o_ack,
    output logic                  o_eof_sent,
    output logic [BE_W-1:0]       o_bsel_nxt
);

    localparam logic [BE_W-1:0] FULL_LAST = BE_W'(IN_BYTES - 1);

    logic [BE_W-1:0] last;
    logic            at_last;
    logic            advance;

    // Lane mux written as a compare loop so that an out-of-range lane index
    // simply yields 00 instead of reading past the word.
    always_comb begin
        o_byte = 8'h00;
        for (int i = 0; i < IN_BYTES; i++) begin
            if (i_bsel == BE_W'(i)) begin
                o_byte = i_data[8*i +: 8];
            end
        end
    end

    assign last       = i_eof ? i_be : FULL_LAST;
    assign at_last    = (i_bsel == last);
    assign advance    = i_val && i_active;
    assign o_ack      = advance && at_last;
    assign o_eof_sent = o_ack && i_eof;

    // The lane index only moves on a valid payload byte; an underrun holds it
    // so the interrupted word resumes at the same byte.
    assign o_bsel_nxt = advance ? (at_last ? '0 : i_bsel + BE_W'(1)) : i_bsel;

endmodule

// File: rtl/tx_rs_framer.sv
// ---------------------------------------------------------------------------
// tx_rs_framer
// Serialises frames from the MTL read-out word interface to one byte per
// cycle, framed into RS blocks: preamble, 15-bit length, payload, 00 padding
// up to a whole block, then check-symbol slots for the downstream encoder.
// Blocks may split an input word; the lane index survives the check slots.
//
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_ari_val/sof/eof      input word qualifiers
//   i_ari_be               last valid byte index on the EOF word
//   i_ari_data             input word, byte 0 sent first
//   o_ari_ack              word consumed (combinational)
//   i_ari_frame_len(_val)  payload length of the frame being started
//   o_sof                  registered, high with the preamble byte
//   o_data                 registered output symbol
//   o_rs_data_symbol       o_data belongs to the RS data part of a block
//   o_rs_check_symbol      reserved check-slot symbol, o_data is 00
//   o_len_err              pulse, payload count at EOF differs from length
//   o_underrun             pulse, input word missing during payload
// ---------------------------------------------------------------------------
module tx_rs_framer
    import tx_rs_pkg::*;
#(
    parameter int         IN_BYTES = 4,
    parameter int         RS_N     = 255,
    parameter int         RS_K     = 239,
    parameter int         CHK_PAD  = 7,
    parameter logic [7:0] PRE_BYTE = 8'h55
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_ari_val,
    input  logic                          i_ari_sof,
    input  logic                          i_ari_eof,
    input  logic [be_width(IN_BYTES)-1:0] i_ari_be,
    input  logic [8*IN_BYTES-1:0]         i_ari_data,
    output logic                          o_ari_ack,
    input  logic [14:0]                   i_ari_frame_len,
    input  logic                          i_ari_frame_len_val,
    output logic                          o_sof,
    output logic [7:0]                    o_data,
    output logic                          o_rs_data_symbol,
    output logic                          o_rs_check_symbol,
    output logic                          o_len_err,
    output logic                          o_underrun
);

    localparam int               BE_W      = be_width(IN_BYTES);
    localparam int               RS_R      = rs_r(RS_N, RS_K, CHK_PAD);
    localparam logic [BLK_W-1:0] DATA_LAST = BLK_W'(RS_K - 1);
    localparam logic [BLK_W-1:0] CHK_LAST  = BLK_W'(RS_R - 1);

    tx_state_t        state;
    tx_state_t        state_nxt;
    logic [BLK_W-1:0] r_blk;
    logic [BE_W-1:0]  r_bsel;
    logic [BE_W-1:0]  bsel_nxt;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_pcnt;
    logic             r_pend;
    logic [7:0]       lane_byte;
    logic [7:0]       data_nxt;
    logic             in_data;
    logic             data_wrap;
    logic             chk_done;
    logic             eof_sent;
    logic             start_ok;

    assign in_data   = (state == ST_DATA);
    assign data_wrap = (r_blk == DATA_LAST);
    assign chk_done  = (r_blk == CHK_LAST);
    assign start_ok  = i_ari_val && i_ari_sof && i_ari_frame_len_val;

    tx_byte_unpacker #(
        .IN_BYTES (IN_BYTES),
        .BE_W     (BE_W)
    ) u_unpack (
        .i_data     (i_ari_data),
        .i_be       (i_ari_be),
        .i_eof      (i_ari_eof),
        .i_val      (i_ari_val),
        .i_active   (in_data),
        .i_bsel     (r_bsel),
        .o_byte     (lane_byte),
        .o_ack      (o_ari_ack),
        .o_eof_sent (eof_sent),
        .o_bsel_nxt (bsel_nxt)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and the symbol to register. Leaving the check slots, an
    // unfinished frame (open lane index or EOF still to come) always resumes
    // payload before any new frame can start.
    always_comb begin
        state_nxt = state;
        data_nxt  = 8'h00;
        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    state_nxt = ST_SOF;
                end
            end
            ST_SOF: begin
                data_nxt  = PRE_BYTE;
                state_nxt = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                data_nxt  = r_len[7:0];
                state_nxt = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                data_nxt  = {1'b0, r_len[14:8]};
                state_nxt = ST_DATA;
            end
            ST_DATA: begin
                data_nxt = i_ari_val ? lane_byte : 8'h00;
                if (data_wrap) begin
                    state_nxt = ST_CHECK;
                end else if (eof_sent) begin
                    state_nxt = ST_DUMMY;
                end
            end
            ST_DUMMY: begin
                if (data_wrap) begin
                    state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (chk_done) begin
                    if ((r_bsel != '0) || r_pend) begin
                        state_nxt = ST_DATA;
                    end else if (i_ari_val && !i_ari_sof) begin
                        state_nxt = ST_DATA;
                    end else if (start_ok) begin
                        state_nxt = ST_SOF;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Block position, lane index, latched length and payload count. r_pend
    // marks a frame whose EOF byte has not gone out yet, so a block boundary
    // that lands exactly on a word boundary still resumes the same frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_blk  <= '0;
            r_bsel <= '0;
            r_len  <= '0;
            r_pcnt <= '0;
            r_pend <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    r_blk  <= '0;
                    r_bsel <= '0;
                    r_pend <= 1'b0;
                end
                ST_CHECK: begin
                    r_blk <= chk_done ? '0 : r_blk + BLK_W'(1);
                end
                default: begin
                    r_blk <= data_wrap ? '0 : r_blk + BLK_W'(1);
                    if (state == ST_SOF) begin
                        r_len  <= i_ari_frame_len;
                        r_pcnt <= '0;
                        r_bsel <= '0;
                        r_pend <= 1'b1;
                    end
                    if (in_data) begin
                        r_bsel <= bsel_nxt;
                        if (i_ari_val) begin
                            r_pcnt <= r_pcnt + LEN_W'(1);
                        end
                        if (eof_sent) begin
                            r_pend <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    // Registered outputs; the length check sees the EOF byte itself through
    // the +1, so the error pulse lines up with that byte on o_data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_sof             <= 1'b0;
            o_data            <= 8'h00;
            o_rs_data_symbol  <= 1'b0;
            o_rs_check_symbol <= 1'b0;
            o_len_err         <= 1'b0;
            o_underrun        <= 1'b0;
        end else begin
            o_sof             <= (state == ST_SOF);
            o_data            <= data_nxt;
            o_rs_data_symbol  <= (state != ST_IDLE) && (state != ST_CHECK);
            o_rs_check_symbol <= (state == ST_CHECK);
            o_len_err         <= eof_sent && ((r_pcnt + LEN_W'(1)) != r_len);
            o_underrun        <= in_data && !i_ari_val;
        end
    end

endmodule

// File: tb/tb_tx_rs_framer.sv
// ---------------------------------------------------------------------------
// tb_tx_rs_framer
// Self-checking bench for tx_rs_framer with 4 byte lanes and 12+4 RS blocks.
// A source model presents words and advances on ack; the expected output
// stream is built from the frame description and compared cycle by cycle.
// ---------------------------------------------------------------------------
module tb_tx_rs_framer;

    localparam int IN_BYTES = 4;
    localparam int RS_N     = 16;
    localparam int RS_K     = 12;
    localparam int CHK_PAD  = 0;
    localparam int RS_R     = 4;

    typedef struct {
        logic       sof;
        logic [7:0] data;
        logic       dsym;
        logic       csym;
        logic       lerr;
        logic       ur;
    } exp_t;

    typedef struct {
        logic [31:0] data;
        logic        sof;
        logic        eof;
        logic [1:0]  be;
        logic [14:0] len;
    } word_t;

    typedef struct {
        int         len_decl;
        int         nbytes;
        logic [7:0] base;
        int         exp_acks;
        int         exp_lerr;
    } vec_t;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b1;
    logic        i_ari_val = 1'b0;
    logic        i_ari_sof = 1'b0;
    logic        i_ari_eof = 1'b0;
    logic [1:0]  i_ari_be = '0;
    logic [31:0] i_ari_data = '0;
    logic        o_ari_ack;
    logic [14:0] i_ari_frame_len = '0;
    logic        i_ari_frame_len_val = 1'b0;
    logic        o_sof;
    logic [7:0]  o_data;
    logic        o_rs_data_symbol;
    logic        o_rs_check_symbol;
    logic        o_len_err;
    logic        o_underrun;

    exp_t  exp_q[$];
    word_t src_q[$];
    vec_t  vecs[10];
    int    compared = 0;
    int    mismatched = 0;
    int    rec_idx = 0;
    int    acks = 0;
    int    lerr_seen = 0;
    int    ur_seen = 0;
    logic  took = 1'b0;
    string scen = "init";

    tx_rs_framer #(
        .IN_BYTES (IN_BYTES),
        .RS_N     (RS_N),
        .RS_K     (RS_K),
        .CHK_PAD  (CHK_PAD),
        .PRE_BYTE (8'h55)
    ) dut (
        .i_clk               (i_clk),
        .i_rst_n             (i_rst_n),
        .i_ari_val           (i_ari_val),
        .i_ari_sof           (i_ari_sof),
        .i_ari_eof           (i_ari_eof),
        .i_ari_be            (i_ari_be),
        .i_ari_data          (i_ari_data),
        .o_ari_ack           (o_ari_ack),
        .i_ari_frame_len     (i_ari_frame_len),
        .i_ari_frame_len_val (i_ari_frame_len_val),
        .o_sof               (o_sof),
        .o_data              (o_data),
        .o_rs_data_symbol    (o_rs_data_symbol),
        .o_rs_check_symbol   (o_rs_check_symbol),
        .o_len_err           (o_len_err),
        .o_underrun          (o_underrun)
    );

    always #5 i_clk = ~i_clk;

    function automatic exp_t mk(input logic s, input logic [7:0] d, input logic ds,
                                input logic cs, input logic le, input logic u);
        exp_t r;
        r.sof  = s;
        r.data = d;
        r.dsym = ds;
        r.csym = cs;
        r.lerr = le;
        r.ur   = u;
        return r;
    endfunction

    function automatic logic [7:0] pbyte(input logic [7:0] base, input int i);
        return 8'(int'(base) + 17 * i);
    endfunction

    task automatic checkCount(input string name, input int got, input int want);
        compared++;
        if (got != want) begin
            mismatched++;
            $display("[TB] FAIL %s %s: got %0d, want %0d", scen, name, got, want);
        end
    endtask

    // Drive the head word; val is withheld in the cycle whose output record
    // is an underrun symbol.
    task automatic applyStimulus();
        logic drop;
        drop = (exp_q.size() > 1) && exp_q[1].ur;
        if (src_q.size() > 0) begin
            i_ari_val           = !drop;
            i_ari_sof           = src_q[0].sof;
            i_ari_eof           = src_q[0].eof;
            i_ari_be            = src_q[0].be;
            i_ari_data          = src_q[0].data;
            i_ari_frame_len     = src_q[0].len;
            i_ari_frame_len_val = src_q[0].sof;
        end else begin
            i_ari_val           = 1'b0;
            i_ari_sof           = 1'b0;
            i_ari_eof           = 1'b0;
            i_ari_be            = '0;
            i_ari_data          = '0;
            i_ari_frame_len     = '0;
            i_ari_frame_len_val = 1'b0;
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (o_len_err) lerr_seen++;
        if (o_underrun) ur_seen++;
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        compared++;
        if ({o_sof, o_data, o_rs_data_symbol, o_rs_check_symbol, o_len_err, o_underrun} !==
            {e.sof, e.data, e.dsym, e.csym, e.lerr, e.ur}) begin
            mismatched++;
            $display("[TB] FAIL %s rec%0d: got sof=%b data=%02h dsym=%b csym=%b lerr=%b ur=%b, want sof=%b data=%02h dsym=%b csym=%b lerr=%b ur=%b",
                     scen, rec_idx, o_sof, o_data, o_rs_data_symbol, o_rs_check_symbol, o_len_err, o_underrun,
                     e.sof, e.data, e.dsym, e.csym, e.lerr, e.ur);
        end
        rec_idx++;
    endtask

    task automatic tick();
        @(negedge i_clk);
        checkOutput();
        took = i_ari_val && o_ari_ack;
        @(posedge i_clk);
        #1;
        if (took) begin
            acks++;
            if (src_q.size() > 0) src_q.delete(0);
        end
        applyStimulus();
    endtask

    task automatic pushIdle(input int n);
        repeat (n) exp_q.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
    endtask

    // Queue the source words of one frame and its expected symbol stream:
    // header and payload fill RS_K-slot blocks, each followed by RS_R checks.
    task automatic buildFrame(input int len_decl, input int n, input logic [7:0] base,
                              input int ur_at, input int ur_len);
        exp_t        slots[$];
        word_t       w;
        logic [14:0] lv;
        int          nw;
        lv = 15'(len_decl);
        slots.push_back(mk(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0));
        slots.push_back(mk(1'b0, lv[7:0], 1'b1, 1'b0, 1'b0, 1'b0));
        slots.push_back(mk(1'b0, {1'b0, lv[14:8]}, 1'b1, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < n; i++) begin
            if (i == ur_at) begin
                repeat (ur_len) slots.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1));
            end
            slots.push_back(mk(1'b0, pbyte(base, i), 1'b1, 1'b0, (i == n - 1) && (n != len_decl), 1'b0));
        end
        while ((slots.size() % RS_K) != 0) begin
            slots.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0));
        end
        for (int j = 0; j < slots.size(); j++) begin
            exp_q.push_back(slots[j]);
            if (((j + 1) % RS_K) == 0) begin
                repeat (RS_R) exp_q.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0));
            end
        end
        nw = (n + 3) / 4;
        for (int k = 0; k < nw; k++) begin
            w.data = 32'hEEEE_EEEE;
            for (int b = 0; b < 4; b++) begin
                if (4 * k + b < n) w.data[8*b +: 8] = pbyte(base, 4 * k + b);
            end
            w.sof = (k == 0);
            w.eof = (k == nw - 1);
            w.be  = w.eof ? 2'((n - 1) % 4) : 2'(k + 1);
            w.len = lv;
            src_q.push_back(w);
        end
    endtask

    task automatic runStream();
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 4000) begin
            tick();
            guard++;
        end
        if (exp_q.size() > 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s timeout: got %0d records left, want 0", scen, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        word_t stray;

        vecs[0] = '{9,  9,  8'h11, 3, 0};
        vecs[1] = '{5,  5,  8'h11, 2, 0};
        vecs[2] = '{12, 12, 8'h11, 3, 0};
        vecs[3] = '{6,  5,  8'h11, 2, 1};
        vecs[4] = '{6,  6,  8'h21, 2, 0};
        vecs[5] = '{7,  7,  8'h31, 2, 0};
        vecs[6] = '{30, 30, 8'h05, 8, 0};
        vecs[7] = '{21, 21, 8'h40, 6, 0};
        vecs[8] = '{4,  4,  8'h70, 1, 0};
        vecs[9] = '{3,  4,  8'h80, 1, 1};

        scen = "reset";
        #1 i_rst_n = 1'b0;
        #2;
        checkCount("reset_outputs",
                   int'({o_sof, o_data, o_rs_data_symbol, o_rs_check_symbol, o_len_err, o_underrun, o_ari_ack}), 0);
        @(posedge i_clk);
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        applyStimulus();
        pushIdle(3);
        runStream();

        foreach (vecs[v]) begin
            scen = $sformatf("vec%0d_len%0d", v, vecs[v].len_decl);
            acks = 0;
            lerr_seen = 0;
            pushIdle(2);
            buildFrame(vecs[v].len_decl, vecs[v].nbytes, vecs[v].base, -1, 0);
            pushIdle(2);
            applyStimulus();
            runStream();
            checkCount("acks", acks, vecs[v].exp_acks);
            checkCount("len_err_pulses", lerr_seen, vecs[v].exp_lerr);
            checkCount("words_left", src_q.size(), 0);
        end

        scen = "back_to_back_underrun";
        acks = 0;
        lerr_seen = 0;
        ur_seen = 0;
        pushIdle(2);
        buildFrame(9, 9, 8'h11, -1, 0);
        buildFrame(10, 10, 8'hA0, 2, 2);
        pushIdle(3);
        applyStimulus();
        runStream();
        checkCount("acks", acks, 6);
        checkCount("underrun_pulses", ur_seen, 2);
        checkCount("len_err_pulses", lerr_seen, 0);

        scen = "reset_mid_frame";
        pushIdle(2);
        buildFrame(9, 9, 8'h11, -1, 0);
        applyStimulus();
        repeat (8) tick();
        #1 i_rst_n = 1'b0;
        #1;
        checkCount("reset_outputs",
                   int'({o_sof, o_data, o_rs_data_symbol, o_rs_check_symbol, o_len_err, o_underrun, o_ari_ack}), 0);
        exp_q.delete();
        src_q.delete();
        stray.data = 32'hDEAD_BEEF;
        stray.sof  = 1'b0;
        stray.eof  = 1'b0;
        stray.be   = 2'd0;
        stray.len  = 15'd0;
        src_q.push_back(stray);
        acks = 0;
        pushIdle(3);
        applyStimulus();
        runStream();
        i_rst_n = 1'b1;
        pushIdle(4);
        runStream();
        checkCount("acks_nonsof_idle", acks, 0);
        src_q.delete();
        acks = 0;
        pushIdle(2);
        buildFrame(5, 5, 8'h61, -1, 0);
        pushIdle(2);
        applyStimulus();
        runStream();
        checkCount("acks_after_reset", acks, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
